vec_mac_unit: RTL and testbench

Four-lane signed fixed-point multiply-accumulate stage that sits directly upstream of the vector ReLU unit. It accepts pairs of 128-bit operand vectors, each holding 4 × 32-bit signed Q16.16 lanes, and accumulates one product per lane per beat. On the last beat of a group it emits one 128-bit vector of rescaled, saturated 32-bit lane results. Lane packing matches the ReLU input, so `out_data` connects straight to it.

---
 rtl/vec_mac_if.sv | 37 +++
 rtl/vec_mac_unit.sv | 112 +++++++++++
 tb/tb_vec_mac_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mac_if.sv
// vec_mac_unit handshake bundle.
// Operand beat channel in, result vector channel out.
interface vec_mac_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_beats;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_beats
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_beats
  );
endinterface

// File: rtl/vec_mac_unit.sv
// Four-lane Q16.16 multiply-accumulate stage.
// Product register, accumulator, rescaled saturated result register.
module vec_mac_unit #(
  parameter int FRAC_SHIFT = 16,
  parameter int ACC_W      = 72
) (
  input logic      clk,
  input logic      rst,
  vec_mac_if.slave bus
);

  logic                    s1_valid;
  logic                    s1_last;
  logic signed [63:0]      s1_p [4];
  logic signed [63:0]      prod [4];
  logic                    s1_adv;
  logic                    accept;

  logic signed [ACC_W-1:0] acc [4];
  logic signed [ACC_W-1:0] acc_nxt [4];
  logic signed [ACC_W-1:0] shifted [4];
  logic [15:0]             beat_cnt;
  logic [15:0]             cnt_nxt;
  logic                    first;

  logic                    out_valid;
  logic [127:0]            out_data;
  logic [127:0]            sat_nxt;
  logic [15:0]             out_beats;

  // A last beat may only leave S1 once the result register is free.
  assign s1_adv = s1_valid &&
    !(s1_last && out_valid && !bus.out_ready);
  assign bus.in_ready = !s1_valid || s1_adv;
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_beats = out_beats;

  // Full-width signed lane products.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i] = 64'($signed(bus.in_a[32*i +: 32])) *
                64'($signed(bus.in_b[32*i +: 32]));
    end
  end

  // Next accumulator, beat count and saturated rescale.
  always_comb begin
    cnt_nxt = first ? 16'd1 :
      (&beat_cnt ? beat_cnt : beat_cnt + 16'd1);
    sat_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      acc_nxt[i] = first ? ACC_W'(s1_p[i]) :
        acc[i] + ACC_W'(s1_p[i]);
      shifted[i] = acc_nxt[i] >>> FRAC_SHIFT;
      if (&shifted[i][ACC_W-1:31] ||
          ~|shifted[i][ACC_W-1:31]) begin
        sat_nxt[32*i +: 32] = shifted[i][31:0];
      end else if (shifted[i][ACC_W-1]) begin
        sat_nxt[32*i +: 32] = 32'h8000_0000;
      end else begin
        sat_nxt[32*i +: 32] = 32'h7FFF_FFFF;
      end
    end
  end

  // S1 product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < 4; i++) s1_p[i] <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_last  <= bus.in_last;
      for (int i = 0; i < 4; i++) s1_p[i] <= prod[i];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 accumulators and group tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      beat_cnt <= '0;
      first    <= 1'b1;
    end else if (s1_adv) begin
      for (int i = 0; i < 4; i++) acc[i] <= acc_nxt[i];
      beat_cnt <= cnt_nxt;
      first    <= s1_last;
    end
  end

  // Result register, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (s1_adv && s1_last) begin
      out_valid <= 1'b1;
      out_data  <= sat_nxt;
      out_beats <= cnt_nxt;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_mac_unit.sv
// Bench for vec_mac_unit: directed cases plus random
// traffic against a group-level arithmetic model.
module tb_vec_mac_unit;

  logic clk = 1'b0;
  logic rst;

  vec_mac_if bus();

  vec_mac_unit #(
    .FRAC_SHIFT(16),
    .ACC_W(72)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Group-level model: running sums per lane, result queue.
  logic signed [71:0] m_acc [4];
  int                 m_cnt = 0;
  bit                 m_first = 1'b1;
  logic [143:0]       exp_q [$];
  logic [31:0]        seen [$];
  int                 stall_cnt = 0;
  int                 ov_run = 0;
  int                 ov_run_max = 0;
  bit                 done = 1'b0;

  function automatic logic [31:0] sat32(logic signed [71:0] v);
    logic signed [71:0] s;
    s = v >>> 16;
    if (s > 72'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -72'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic model_beat(input logic [127:0] a,
                            input logic [127:0] b,
                            input logic last);
    longint p;
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      p = longint'($signed(a[32*i +: 32])) *
          longint'($signed(b[32*i +: 32]));
      if (m_first) m_acc[i] = 72'(p);
      else m_acc[i] = m_acc[i] + 72'(p);
      d[32*i +: 32] = sat32(m_acc[i]);
    end
    if (m_first) m_cnt = 1;
    else if (m_cnt < 65535) m_cnt = m_cnt + 1;
    if (last) begin
      exp_q.push_back({16'(m_cnt), d});
      m_first = 1'b1;
    end else begin
      m_first = 1'b0;
    end
  endtask

  // Compare outputs against the model every cycle.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected",
              {127'd0, bus.out_valid}, 128'd0);
      end else begin
        check("out_data", bus.out_data, exp_q[0][127:0]);
        check("out_beats", {112'd0, bus.out_beats},
              {112'd0, exp_q[0][143:128]});
        if (bus.out_ready && !rst) begin
          seen.push_back(bus.out_data[31:0]);
          void'(exp_q.pop_front());
        end
      end
      ov_run++;
      if (ov_run > ov_run_max) ov_run_max = ov_run;
    end else begin
      ov_run = 0;
    end
    if (rst) begin
      exp_q.delete();
      m_first = 1'b1;
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_acc[i] = '0;
    end else if (bus.in_valid && bus.in_ready) begin
      model_beat(bus.in_a, bus.in_b, bus.in_last);
    end
  end

  function automatic logic [127:0] rep(input logic [31:0] x);
    return {4{x}};
  endfunction

  task automatic send(input logic [127:0] a,
                      input logic [127:0] b,
                      input logic last);
    int w;
    logic ok;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_last = last;
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      w++;
      stall_cnt++;
      if (w > 300) begin
        checks++;
        $display("FAIL send_timeout: got stalled expected accept");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [127:0] d,
                          output logic [15:0] n);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      k++;
      if (k > 50) begin
        checks++;
        $display("FAIL out_timeout: got no out_valid expected 1");
        break;
      end
    end
    d = bus.out_data;
    n = bus.out_beats;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b, d;
    logic [15:0]  n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("rst_out_data", bus.out_data, 128'd0);
    check("rst_out_beats", {112'd0, bus.out_beats}, 128'd0);
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;

    // single beat, 2.0 * 3.0
    send(rep(32'h0002_0000), rep(32'h0003_0000), 1'b1);
    @(negedge clk);
    check("single_early", {127'd0, bus.out_valid}, 128'd0);
    @(negedge clk);
    check("single_valid", {127'd0, bus.out_valid}, 128'd1);
    check("single_data", bus.out_data, rep(32'h0006_0000));
    check("single_beats", {112'd0, bus.out_beats}, 128'd1);
    @(negedge clk);
    check("single_pulse", {127'd0, bus.out_valid}, 128'd0);
    @(posedge clk);
    #1;

    // signed 3-beat group
    a = {32'h0, 32'h0000_8000, 32'hFFFF_0000, 32'h0001_0000};
    b = {$urandom(), 32'h0000_8000, 32'h0002_0000,
         32'h0001_0000};
    send(a, b, 1'b0);
    send(a, b, 1'b0);
    send(a, b, 1'b1);
    wait_out(d, n);
    check("grp3_data", d,
          {32'h0, 32'h0000_C000, 32'hFFFA_0000, 32'h0003_0000});
    check("grp3_beats", {112'd0, n}, 128'd3);

    // saturation and floor
    a = {32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    b = {32'h0, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
    send(a, b, 1'b1);
    wait_out(d, n);
    check("sat_data", d,
          {32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF});

    // backpressure, four 1-beat groups
    bus.out_ready = 1'b0;
    seen.delete();
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send(rep(32'(k) << 16), rep(32'h0001_0000), 1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready_low", {127'd0, bus.in_ready}, 128'd0);
        check("bp_valid", {127'd0, bus.out_valid}, 128'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_hold", bus.out_data, rep(32'h0001_0000));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    check("bp_count", 128'(seen.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      check("bp_order",
            (k < seen.size()) ? 128'(seen[k]) : 128'hDEAD,
            128'(32'(k + 1) << 16));
    end
    @(posedge clk);
    #1;

    // reset in the middle of a group
    send(rep(32'h0005_0000), rep(32'h0001_0000), 1'b0);
    send(rep(32'h0005_0000), rep(32'h0001_0000), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {127'd0, bus.out_valid}, 128'd0);
    check("mid_rst_data", bus.out_data, 128'd0);
    check("mid_rst_beats", {112'd0, bus.out_beats}, 128'd0);
    check("mid_rst_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    send(rep(32'h0001_0000), rep(32'h0001_0000), 1'b1);
    wait_out(d, n);
    check("mid_rst_data2", d, rep(32'h0001_0000));
    check("mid_rst_beats2", {112'd0, n}, 128'd1);

    // back-to-back 1-beat groups
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    stall_cnt = 0;
    ov_run_max = 0;
    seen.delete();
    for (int k = 1; k <= 10; k++)
      send(rep(32'(k) << 16), rep(32'h0001_0000), 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_stalls", 128'(stall_cnt), 128'd0);
    check("b2b_run", 128'(ov_run_max), 128'd10);
    check("b2b_count", 128'(seen.size()), 128'd10);
    for (int k = 0; k < 10; k++) begin
      check("b2b_order",
            (k < seen.size()) ? 128'(seen[k]) : 128'hDEAD,
            128'(32'(k + 1) << 16));
    end
    @(posedge clk);
    #1;

    // random traffic with random backpressure
    fork
      begin
        for (int t = 0; t < 400; t++) begin
          logic [127:0] ra, rb;
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          for (int l = 0; l < 4; l++) begin
            if ($urandom_range(3) == 0) begin
              ra[32*l +: 32] = $urandom();
              rb[32*l +: 32] = $urandom();
            end else begin
              ra[32*l +: 32] = $urandom_range(32'h80000)
                               - 32'h40000;
              rb[32*l +: 32] = $urandom_range(32'h80000)
                               - 32'h40000;
            end
          end
          send(ra, rb, $urandom_range(3) == 0);
        end
        send(rep(32'h0001_0000), rep(32'h0001_0000), 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(9) < 7);
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
